// File: rtl/hit_sched.sv
// hit_sched: pops one ray at a time and issues one ray/triangle job per triangle,
// reading the triangle memory one cycle ahead so a non-stalled ray streams at one job per clock.
module hit_sched #(
  parameter int unsigned D_BITS = 32,
  parameter int unsigned M_BITS = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [M_BITS-1:0]     num_tris,
  input  logic                  ray_empty,
  output logic                  ray_rd_en,
  input  logic [M_BITS-1:0]     ray_id_din,
  input  logic [3*D_BITS-1:0]   ray_origin_din,
  input  logic [3*D_BITS-1:0]   ray_dir_din,
  output logic                  tri_rd_en,
  output logic [M_BITS-1:0]     tri_addr,
  input  logic [3*D_BITS-1:0]   tri_v0,
  input  logic [3*D_BITS-1:0]   tri_v1,
  input  logic [3*D_BITS-1:0]   tri_v2,
  input  logic [3*D_BITS-1:0]   tri_normal,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [M_BITS-1:0]     out_ray_id,
  output logic [M_BITS-1:0]     out_tri_id,
  output logic [3*D_BITS-1:0]   out_ray_origin,
  output logic [3*D_BITS-1:0]   out_ray_dir,
  output logic [3*D_BITS-1:0]   out_v0,
  output logic [3*D_BITS-1:0]   out_v1,
  output logic [3*D_BITS-1:0]   out_v2,
  output logic [3*D_BITS-1:0]   out_normal,
  output logic                  out_last,
  output logic                  busy,
  output logic [31:0]           rays_done
);

  localparam int unsigned V_BITS = 3 * D_BITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [M_BITS-1:0] r_ray_id;
  logic [V_BITS-1:0] r_origin;
  logic [V_BITS-1:0] r_dir;
  logic [M_BITS-1:0] r_num;
  logic [M_BITS-1:0] r_cur;
  logic [31:0]       r_rays_done;

  logic w_pop;
  logic w_wr;
  logic w_last;
  logic w_ray_done;

  // Handshake terms shared by the FSM, the datapath and the outputs
  assign w_pop      = (r_state == S_IDLE) && enable && !ray_empty;
  assign w_last     = (r_cur == (r_num - M_BITS'(1)));
  assign w_wr       = (r_state == S_WRITE) && !out_full;
  assign w_ray_done = ((r_state == S_LOAD) && (r_num == '0)) || (w_wr && w_last);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_next = S_LOAD;
      S_LOAD:  w_next = (r_num == '0) ? S_IDLE : S_READ;
      S_READ:  w_next = S_WRITE;
      S_WRITE: if (w_wr && w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Ray latch, triangle counter and completed-ray counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ray_id    <= '0;
      r_origin    <= '0;
      r_dir       <= '0;
      r_num       <= '0;
      r_cur       <= '0;
      r_rays_done <= '0;
    end else begin
      if (w_pop) begin
        r_ray_id <= ray_id_din;
        r_origin <= ray_origin_din;
        r_dir    <= ray_dir_din;
        r_num    <= num_tris;
        r_cur    <= '0;
      end else if (w_wr) begin
        // Park the counter at zero once the ray is finished so tri_addr idles at zero
        r_cur <= w_last ? '0 : (r_cur + M_BITS'(1));
      end
      if (w_ray_done) begin
        r_rays_done <= r_rays_done + 32'd1;
      end
    end
  end

  // Strobes and address; the next triangle is fetched in the same cycle the current job is written
  always_comb begin
    ray_rd_en = 1'b0;
    tri_rd_en = 1'b0;
    tri_addr  = '0;
    out_wr_en = 1'b0;
    out_last  = 1'b0;
    busy      = (r_state != S_IDLE);
    if (!reset) begin
      ray_rd_en = w_pop;
    end
    case (r_state)
      S_READ: begin
        tri_rd_en = 1'b1;
        tri_addr  = r_cur;
      end
      S_WRITE: begin
        out_wr_en = w_wr;
        out_last  = w_last;
        tri_rd_en = w_wr && !w_last;
        tri_addr  = r_cur + M_BITS'(1);
      end
      default: begin
        tri_addr = '0;
      end
    endcase
  end

  // Job payload: latched ray, memory data passed straight through
  assign out_ray_id     = r_ray_id;
  assign out_tri_id     = r_cur;
  assign out_ray_origin = r_origin;
  assign out_ray_dir    = r_dir;
  assign out_v0         = tri_v0;
  assign out_v1         = tri_v1;
  assign out_v2         = tri_v2;
  assign out_normal     = tri_normal;
  assign rays_done      = r_rays_done;

endmodule

// File: tb/tb_hit_sched.sv
// Directed bench for hit_sched with a show-ahead ray FIFO model and a registered triangle memory model.
module tb_hit_sched;

  localparam int unsigned D = 32;
  localparam int unsigned M = 12;
  localparam int unsigned V = 3 * D;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [M-1:0]  num_tris = '0;
  logic          ray_empty;
  logic          ray_rd_en;
  logic [M-1:0]  ray_id_din;
  logic [V-1:0]  ray_origin_din;
  logic [V-1:0]  ray_dir_din;
  logic          tri_rd_en;
  logic [M-1:0]  tri_addr;
  logic [V-1:0]  tri_v0 = '0;
  logic [V-1:0]  tri_v1 = '0;
  logic [V-1:0]  tri_v2 = '0;
  logic [V-1:0]  tri_normal = '0;
  logic          out_full = 1'b0;
  logic          out_wr_en;
  logic [M-1:0]  out_ray_id;
  logic [M-1:0]  out_tri_id;
  logic [V-1:0]  out_ray_origin;
  logic [V-1:0]  out_ray_dir;
  logic [V-1:0]  out_v0;
  logic [V-1:0]  out_v1;
  logic [V-1:0]  out_v2;
  logic [V-1:0]  out_normal;
  logic          out_last;
  logic          busy;
  logic [31:0]   rays_done;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  int rq_id [32];
  int rq_head = 0;
  int rq_tail = 0;

  int log_ray [64];
  int log_tri [64];
  int log_last[64];
  int log_cyc [64];
  int nlog = 0;
  int pop_cyc [16];
  int npop = 0;

  hit_sched #(.D_BITS(D), .M_BITS(M)) dut (
    .clock(clock), .reset(reset), .enable(enable), .num_tris(num_tris),
    .ray_empty(ray_empty), .ray_rd_en(ray_rd_en), .ray_id_din(ray_id_din),
    .ray_origin_din(ray_origin_din), .ray_dir_din(ray_dir_din),
    .tri_rd_en(tri_rd_en), .tri_addr(tri_addr),
    .tri_v0(tri_v0), .tri_v1(tri_v1), .tri_v2(tri_v2), .tri_normal(tri_normal),
    .out_full(out_full), .out_wr_en(out_wr_en),
    .out_ray_id(out_ray_id), .out_tri_id(out_tri_id),
    .out_ray_origin(out_ray_origin), .out_ray_dir(out_ray_dir),
    .out_v0(out_v0), .out_v1(out_v1), .out_v2(out_v2), .out_normal(out_normal),
    .out_last(out_last), .busy(busy), .rays_done(rays_done)
  );

  always #5 clock = ~clock;

  function automatic logic [V-1:0] ray_pat(input int id, input int k);
    int b;
    b = id * 16 + k * 4;
    return {D'(b + 2), D'(b + 1), D'(b)};
  endfunction

  function automatic logic [V-1:0] tri_pat(input int addr, input int k);
    int b;
    b = 32'h1000 + addr * 16 + k * 4;
    return {D'(b + 2), D'(b + 1), D'(b)};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Show-ahead ray FIFO
  assign ray_empty      = (rq_head == rq_tail);
  assign ray_id_din     = M'(rq_id[rq_head]);
  assign ray_origin_din = ray_pat(rq_id[rq_head], 0);
  assign ray_dir_din    = ray_pat(rq_id[rq_head], 1);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ray_rd_en) rq_head <= rq_head + 1;
    if (tri_rd_en) begin
      tri_v0     <= tri_pat(int'(tri_addr), 0);
      tri_v1     <= tri_pat(int'(tri_addr), 1);
      tri_v2     <= tri_pat(int'(tri_addr), 2);
      tri_normal <= tri_pat(int'(tri_addr), 3);
    end
  end

  // Job and pop monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (!reset && out_wr_en) begin
      log_ray[nlog]  = int'(out_ray_id);
      log_tri[nlog]  = int'(out_tri_id);
      log_last[nlog] = int'(out_last);
      log_cyc[nlog]  = cyc;
      nlog++;
      check_eq("job_origin", out_ray_origin, ray_pat(int'(out_ray_id), 0));
      check_eq("job_dir",    out_ray_dir,    ray_pat(int'(out_ray_id), 1));
      check_eq("job_v0",     out_v0,         tri_pat(int'(out_tri_id), 0));
      check_eq("job_v1",     out_v1,         tri_pat(int'(out_tri_id), 1));
      check_eq("job_v2",     out_v2,         tri_pat(int'(out_tri_id), 2));
      check_eq("job_normal", out_normal,     tri_pat(int'(out_tri_id), 3));
    end
    if (!reset && ray_rd_en) begin
      pop_cyc[npop] = cyc;
      npop++;
      check_eq("pop_wr_overlap", out_wr_en, 0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_ray(input int id);
    rq_id[rq_tail] = id;
    rq_tail++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nlog = 0;
    npop = 0;
  endtask

  task automatic wait_pop(input string tag, output int t);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ray_rd_en) begin
        t = cyc;
        return;
      end
      @(posedge clock);
      #1;
    end
    check_eq({tag, "_pop_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string tag, input bit need_empty);
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #2;
      if (!busy && (!need_empty || ray_empty)) return;
    end
    check_eq({tag, "_idle_timeout"}, 0, 1);
  endtask

  int t;

  initial begin
    // Reset state
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rays_done", rays_done, 0);
    check_eq("rst_ray_rd_en", ray_rd_en, 0);
    check_eq("rst_tri_rd_en", tri_rd_en, 0);
    check_eq("rst_out_wr_en", out_wr_en, 0);
    check_eq("rst_tri_addr", tri_addr, 0);
    check_eq("rst_out_last", out_last, 0);
    tick();
    do_reset();

    // Single ray, four triangles, no back-pressure
    num_tris = M'(4);
    enable = 1'b1;
    push_ray(7);
    wait_pop("t1", t);
    wait_idle("t1", 1'b1);
    check_eq("t1_njobs", nlog, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_ray", log_ray[i], 7);
      check_eq("t1_tri", log_tri[i], i);
      check_eq("t1_last", log_last[i], (i == 3) ? 1 : 0);
      check_eq("t1_cycle", log_cyc[i], t + 3 + i);
    end
    check_eq("t1_rays_done", rays_done, 1);

    // Back-pressure for five cycles while tri_id 1 is presented
    do_reset();
    push_ray(7);
    wait_pop("t2", t);
    repeat (4) tick();
    out_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("t2_stall_wr", out_wr_en, 0);
      check_eq("t2_stall_tri", out_tri_id, 1);
      check_eq("t2_stall_v0", out_v0, tri_pat(1, 0));
      check_eq("t2_stall_norm", out_normal, tri_pat(1, 3));
      check_eq("t2_stall_rd", tri_rd_en, 0);
      tick();
    end
    out_full = 1'b0;
    wait_idle("t2", 1'b1);
    check_eq("t2_njobs", nlog, 4);
    for (int i = 0; i < 4; i++) check_eq("t2_tri", log_tri[i], i);
    check_eq("t2_tri1_cycle", log_cyc[1], t + 9);
    check_eq("t2_tri3_cycle", log_cyc[3], t + 11);
    check_eq("t2_rays_done", rays_done, 1);

    // Three rays with zero triangles
    do_reset();
    num_tris = '0;
    push_ray(11);
    push_ray(12);
    push_ray(13);
    wait_idle("t3", 1'b1);
    check_eq("t3_npop", npop, 3);
    check_eq("t3_njobs", nlog, 0);
    check_eq("t3_rays_done", rays_done, 3);

    // Two back-to-back rays, two triangles each
    do_reset();
    num_tris = M'(2);
    push_ray(1);
    push_ray(2);
    wait_idle("t4", 1'b1);
    check_eq("t4_njobs", nlog, 4);
    check_eq("t4_npop", npop, 2);
    check_eq("t4_j0", {log_ray[0][7:0], log_tri[0][7:0], log_last[0][7:0]}, 24'h010000);
    check_eq("t4_j1", {log_ray[1][7:0], log_tri[1][7:0], log_last[1][7:0]}, 24'h010101);
    check_eq("t4_j2", {log_ray[2][7:0], log_tri[2][7:0], log_last[2][7:0]}, 24'h020000);
    check_eq("t4_j3", {log_ray[3][7:0], log_tri[3][7:0], log_last[3][7:0]}, 24'h020101);
    check_eq("t4_pop2_after_last", pop_cyc[1], log_cyc[1] + 1);
    check_eq("t4_rays_done", rays_done, 2);

    // Reset while tri_id 2 of 8 is being issued
    do_reset();
    num_tris = M'(8);
    push_ray(5);
    wait_pop("t5", t);
    repeat (5) tick();
    #1;
    check_eq("t5_pre_tri", out_tri_id, 2);
    check_eq("t5_pre_wr", out_wr_en, 1);
    reset = 1'b1;
    #1;
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_wr", out_wr_en, 0);
    check_eq("t5_rst_rd", tri_rd_en, 0);
    check_eq("t5_rst_addr", tri_addr, 0);
    check_eq("t5_rst_last", out_last, 0);
    check_eq("t5_rst_done", rays_done, 0);
    tick();
    reset = 1'b0;
    nlog = 0;
    npop = 0;
    repeat (6) tick();
    check_eq("t5_abandoned", nlog, 0);
    push_ray(6);
    wait_idle("t5", 1'b1);
    check_eq("t5_njobs", nlog, 8);
    check_eq("t5_restart_tri", log_tri[0], 0);
    check_eq("t5_restart_ray", log_ray[0], 6);
    check_eq("t5_last7", log_last[7], 1);
    check_eq("t5_last6", log_last[6], 0);

    // Enable dropped mid-ray; num_tris changed after the pop
    do_reset();
    num_tris = M'(3);
    push_ray(3);
    push_ray(4);
    wait_pop("t6", t);
    tick();
    enable = 1'b0;
    num_tris = M'(7);
    wait_idle("t6a", 1'b0);
    repeat (4) tick();
    #1;
    check_eq("t6_npop", npop, 1);
    check_eq("t6_njobs", nlog, 3);
    check_eq("t6_last", log_last[2], 1);
    check_eq("t6_rays_done", rays_done, 1);
    check_eq("t6_no_pop", ray_rd_en, 0);
    num_tris = M'(2);
    enable = 1'b1;
    wait_idle("t6b", 1'b1);
    check_eq("t6_npop2", npop, 2);
    check_eq("t6_njobs2", nlog, 5);
    check_eq("t6_ray2", log_ray[3], 4);
    check_eq("t6_last2", log_last[4], 1);
    check_eq("t6_rays_done2", rays_done, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hit_sched.md
HIT_SCHED -- requirements
Module: hit_sched

Interface
REQ-001 Parameter D_BITS, default 32, width of one fixed-point coordinate word.
REQ-002 Parameter M_BITS, default 12, width of ray and triangle IDs and of the triangle address.
REQ-003 clock  in  1  single clock for the block; all state updates on posedge clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  when low, no new ray is popped; a ray already in progress finishes.
REQ-006 num_tris  in  M_BITS  triangle count, sampled only when a ray is popped.
REQ-007 ray_empty  in  1  ray input FIFO is empty.
REQ-008 ray_rd_en  out  1  pop strobe for the ray input FIFO (show-ahead FIFO).
REQ-009 ray_id_din  in  M_BITS  ID of the ray at the head of the ray FIFO.
REQ-010 ray_origin_din  in  3xD_BITS  origin of the ray at the head of the ray FIFO.
REQ-011 ray_dir_din  in  3xD_BITS  direction of the ray at the head of the ray FIFO.
REQ-012 tri_rd_en  out  1  triangle memory read strobe.
REQ-013 tri_addr  out  M_BITS  triangle memory read address.
REQ-014 tri_v0, tri_v1, tri_v2, tri_normal  in  3xD_BITS each  triangle memory read data.
- Valid in the cycle after tri_rd_en.
- Held stable until the next tri_rd_en.
REQ-015 out_full  in  1  downstream job FIFO is full.
REQ-016 out_wr_en  out  1  job write strobe.
REQ-017 out_ray_id, out_tri_id  out  M_BITS each  IDs of the issued job.
REQ-018 out_ray_origin, out_ray_dir, out_v0, out_v1, out_v2, out_normal  out  3xD_BITS each  payload of the issued job.
REQ-019 out_last  out  1  marks the job carrying the final triangle of a ray.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 rays_done  out  32  count of rays fully issued; wraps modulo 2^32.

Function
REQ-022 States SHALL be IDLE, LOAD, READ, WRITE.
REQ-023 IDLE -> LOAD when enable && !ray_empty; ray_rd_en is pulsed for exactly that cycle.
REQ-024 On that same edge the block SHALL latch ray_id, origin, dir and num_tris, and set the triangle counter cur=0.
REQ-025 LOAD, num_tris==0: the block SHALL increment rays_done and return to IDLE with no job written.
REQ-026 LOAD, num_tris>0: the block SHALL go to READ.
REQ-027 READ: tri_rd_en=1 and tri_addr=cur for one cycle, then WRITE.
REQ-028 WRITE: out_wr_en = !out_full.
- Payload: latched ray fields, memory data passed straight through, out_tri_id=cur.
- out_last=(cur==num_tris_latched-1).
REQ-029 WRITE with out_full high: the block SHALL stay in WRITE with all outputs held and no memory read issued.
REQ-030 WRITE with a write, not last: the block SHALL assert tri_rd_en with tri_addr=cur+1 in the same cycle, increment cur, and stay in WRITE.
- Steady-state throughput: 1 job/clock.
REQ-031 WRITE with a write and last: the block SHALL increment rays_done and go to IDLE.
- IDLE may pop the next ray on the following cycle.
REQ-032 A ray is never popped outside IDLE.
- ray_rd_en and out_wr_en SHALL never be high in the same cycle.
REQ-033 Latency from the ray_rd_en cycle to the first out_wr_en SHALL be 3 cycles (LOAD, READ, WRITE) when out_full is low.
REQ-034 out_wr_en SHALL only assert in WRITE.
- out_* payload outside WRITE is don't-care.
REQ-035 enable falling mid-ray SHALL NOT stop issue; the block only refrains from popping in IDLE.
REQ-036 Changes to num_tris after the pop SHALL have no effect on the current ray.

Reset
REQ-037 Reset SHALL act immediately, including mid-ray. State, outputs and the cur counter SHALL clear as follows:
- state=IDLE
- ray_rd_en=0, tri_rd_en=0, out_wr_en=0
- tri_addr=0, cur=0
- busy=0
- rays_done=0
- out_last=0
REQ-038 A partially issued ray SHALL be abandoned; its remaining triangles are not issued after reset.

Verification
REQ-039 num_tris=4, one ray id=7, out_full=0.
- ray_rd_en at cycle t.
- out_wr_en at t+3..t+6 with tri_id 0,1,2,3.
- out_last only at t+6.
- rays_done=1.
REQ-040 Same setup, out_full held high for 5 cycles during tri_id=1.
- tri_id=1 payload stable for those 5 cycles.
- No tri_rd_en during the stall.
- No duplicate or skipped IDs.
REQ-041 num_tris=0 with 3 rays queued: 3 pops, zero out_wr_en, rays_done=3.
REQ-042 Two back-to-back rays (ids 1,2), num_tris=2.
- Output sequence: (1,0), (1,1,last), (2,0), (2,1,last).
- Ray 2 popped only after ray 1's last write.
REQ-043 Reset asserted during tri_id=2 of num_tris=8.
- Outputs cleared immediately and busy=0.
- Next ray restarts at tri_id=0.
REQ-044 enable dropped mid-ray with num_tris=3: current ray completes; no further pop while enable is low.
